// File: rtl/rv_x_writeback_if.sv
// Bundle of the writeback stage's ALU, load-issue, load-result and operand-query signals.
// RV_X_WRITEBACK_FORWARD_EN adds the commit-cycle forwarding signals.
interface rv_x_writeback_if #(
  parameter int XLEN = 64
);
  // Load results move on a cycle where load_valid & load_ready are both high; the producer
  // keeps load_valid, load_rd and load_value stable until then, and load_ready never looks at load_valid.
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_value;
  logic            load_issue_valid;
  logic [4:0]      load_issue_rd;
  logic            load_issue_stall;
  logic            load_valid;
  logic            load_ready;
  logic [4:0]      load_rd;
  logic [XLEN-1:0] load_value;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_store_value;
`ifdef RV_X_WRITEBACK_FORWARD_EN
  logic            rs1_fwd_valid;
  logic            rs2_fwd_valid;
  logic [XLEN-1:0] rs1_fwd_value;
  logic [XLEN-1:0] rs2_fwd_value;

  modport master (
    output alu_valid, alu_rd, alu_value, load_issue_valid, load_issue_rd,
           load_valid, load_rd, load_value, rs1, rs2,
    input  load_issue_stall, load_ready, rs1_busy, rs2_busy, rd, rd_store_value,
           rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_value, rs2_fwd_value
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value, load_issue_valid, load_issue_rd,
           load_valid, load_rd, load_value, rs1, rs2,
    output load_issue_stall, load_ready, rs1_busy, rs2_busy, rd, rd_store_value,
           rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_value, rs2_fwd_value
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_value, load_issue_valid, load_issue_rd,
           load_valid, load_rd, load_value, rs1, rs2,
    input  load_issue_stall, load_ready, rs1_busy, rs2_busy, rd, rd_store_value
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value, load_issue_valid, load_issue_rd,
           load_valid, load_rd, load_value, rs1, rs2,
    output load_issue_stall, load_ready, rs1_busy, rs2_busy, rd, rd_store_value
  );
`endif
endinterface

// File: rtl/rv_x_writeback.sv
// Integer writeback stage: ALU results win the single register-file write port, load results queue
// in a FIFO, and a pending-load scoreboard flags hazards. Optional macro: RV_X_WRITEBACK_FORWARD_EN.
module rv_x_writeback #(
  parameter bit rv64            = 1'b1,
  parameter int LOAD_FIFO_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  rv_x_writeback_if.slave wb
);
  localparam int XLEN = rv64 ? 64 : 32;
  localparam int PW   = $clog2(LOAD_FIFO_DEPTH);
  localparam int CW   = PW + 1;

  logic [4:0]      r_fifo_rd  [LOAD_FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_val [LOAD_FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_pending;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rd_value;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_sel_alu;
  logic            w_stall;
  logic            w_set;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_val;
  logic [31:0]     w_pending_nxt;

  assign w_full     = (r_count == CW'(LOAD_FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = wb.load_valid & ~w_full;
  assign w_sel_alu  = wb.alu_valid & (wb.alu_rd != 5'd0);
  assign w_pop      = ~w_sel_alu & ~w_empty;
  assign w_head_rd  = r_fifo_rd[r_rd_ptr];
  assign w_head_val = r_fifo_val[r_rd_ptr];

  assign w_stall = wb.load_issue_valid & r_pending[wb.load_issue_rd] & (wb.load_issue_rd != 5'd0);
  assign w_set   = wb.load_issue_valid & ~w_stall & (wb.load_issue_rd != 5'd0);

  // Clear first so a same-cycle set of the same index takes precedence.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop && (w_head_rd != 5'd0)) w_pending_nxt[w_head_rd] = 1'b0;
    if (w_set) w_pending_nxt[wb.load_issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // FIFO storage needs no reset: only pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]  <= wb.load_rd;
      r_fifo_val[r_wr_ptr] <= wb.load_value;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_pending <= w_pending_nxt;
    end
  end

  // Idle cycles drop the write index but keep the data, so rd_store_value only moves on a selection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd       <= 5'd0;
      r_rd_value <= '0;
    end else if (w_sel_alu) begin
      r_rd       <= wb.alu_rd;
      r_rd_value <= wb.alu_value;
    end else if (w_pop) begin
      r_rd       <= w_head_rd;
      r_rd_value <= w_head_val;
    end else begin
      r_rd       <= 5'd0;
    end
  end

  assign wb.load_issue_stall = w_stall;
  assign wb.load_ready       = ~w_full;
  assign wb.rs1_busy         = r_pending[wb.rs1];
  assign wb.rs2_busy         = r_pending[wb.rs2];
  assign wb.rd               = r_rd;
  assign wb.rd_store_value   = r_rd_value;

`ifdef RV_X_WRITEBACK_FORWARD_EN
  assign wb.rs1_fwd_valid = (r_rd != 5'd0) & (r_rd == wb.rs1);
  assign wb.rs2_fwd_valid = (r_rd != 5'd0) & (r_rd == wb.rs2);
  assign wb.rs1_fwd_value = r_rd_value;
  assign wb.rs2_fwd_value = r_rd_value;
`endif
endmodule

// File: tb/tb_rv_x_writeback.sv
// Self-checking bench for rv_x_writeback: a queue model predicts each registered write slot,
// which is compared one cycle later; directed checks cover reset, hazards and FIFO full.
module tb_rv_x_writeback;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int EW    = XLEN + 5;

  logic clock;
  logic reset;
  bit   acc;
  int   li;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   m_fifo[$];
  logic [31:0]     m_pending;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_val;

  rv_x_writeback_if #(.XLEN(XLEN)) bus ();

  rv_x_writeback #(.rv64(1'b1), .LOAD_FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: predicts the write slot each edge produces
  always @(posedge clock) begin
    logic          sel_alu;
    logic          push;
    logic          stall;
    logic [EW-1:0] h;
    if (!reset) begin
      m_fifo.delete();
      m_pending = '0;
      m_rd      = 5'd0;
      m_val     = '0;
    end else begin
      sel_alu = bus.alu_valid && (bus.alu_rd != 5'd0);
      push    = bus.load_valid && (m_fifo.size() < DEPTH);
      stall   = bus.load_issue_valid && m_pending[bus.load_issue_rd] && (bus.load_issue_rd != 5'd0);
      if (sel_alu) begin
        m_rd  = bus.alu_rd;
        m_val = bus.alu_value;
      end else if (m_fifo.size() > 0) begin
        h     = m_fifo.pop_front();
        m_rd  = h[EW-1:XLEN];
        m_val = h[XLEN-1:0];
        if (m_rd != 5'd0) m_pending[m_rd] = 1'b0;
      end else begin
        m_rd = 5'd0;
      end
      if (bus.load_issue_valid && !stall && (bus.load_issue_rd != 5'd0))
        m_pending[bus.load_issue_rd] = 1'b1;
      if (push) m_fifo.push_back({bus.load_rd, bus.load_value});
    end
    exp_q.push_back({m_rd, m_val});
  end

  // scoreboard: compare registered outputs against the prediction
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("wb_rd", 64'(bus.rd), 64'(e[EW-1:XLEN]));
      check_eq("wb_value", bus.rd_store_value, e[XLEN-1:0]);
      check_eq("load_ready", 64'(bus.load_ready), 64'(m_fifo.size() < DEPTH));
    end
  end

  // driver: check combinational outputs, report acceptance, advance to the next negedge
  task automatic tick(output bit accepted);
    #1;
    check_eq("stall", 64'(bus.load_issue_stall),
             64'(bus.load_issue_valid && m_pending[bus.load_issue_rd] && (bus.load_issue_rd != 5'd0)));
    check_eq("rs1_busy", 64'(bus.rs1_busy), 64'(m_pending[bus.rs1]));
    check_eq("rs2_busy", 64'(bus.rs2_busy), 64'(m_pending[bus.rs2]));
`ifdef RV_X_WRITEBACK_FORWARD_EN
    check_eq("rs1_fwd_valid", 64'(bus.rs1_fwd_valid), 64'((m_rd != 5'd0) && (m_rd == bus.rs1)));
    check_eq("rs2_fwd_valid", 64'(bus.rs2_fwd_valid), 64'((m_rd != 5'd0) && (m_rd == bus.rs2)));
    check_eq("rs2_fwd_value", bus.rs2_fwd_value, m_val);
`endif
    accepted = bus.load_valid && bus.load_ready;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.alu_valid        = 1'b0;
    bus.alu_rd           = 5'd0;
    bus.alu_value        = '0;
    bus.load_issue_valid = 1'b0;
    bus.load_issue_rd    = 5'd0;
    bus.load_valid       = 1'b0;
    bus.load_rd          = 5'd0;
    bus.load_value       = '0;
    bus.rs1              = 5'd0;
    bus.rs2              = 5'd0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    tick(acc);

    // ALU path
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_value = 64'h1234;
    tick(acc);
    check_eq("alu_x5_rd", 64'(bus.rd), 64'd5);
    check_eq("alu_x5_value", bus.rd_store_value, 64'h1234);
    bus.alu_rd = 5'd0; bus.alu_value = 64'hbeef;
    tick(acc);
    check_eq("alu_x0_rd", 64'(bus.rd), 64'd0);
    bus.alu_valid = 1'b0;

    // load path
    bus.load_issue_valid = 1'b1; bus.load_issue_rd = 5'd7;
    tick(acc);
    bus.load_issue_valid = 1'b0; bus.rs1 = 5'd7;
    #1 check_eq("busy_x7", 64'(bus.rs1_busy), 64'd1);
    bus.load_valid = 1'b1; bus.load_rd = 5'd7; bus.load_value = 64'hdead;
    tick(acc);
    bus.load_valid = 1'b0;
    tick(acc);
    check_eq("load_x7_rd", 64'(bus.rd), 64'd7);
    check_eq("load_x7_value", bus.rd_store_value, 64'hdead);
    check_eq("busy_x7_clear", 64'(bus.rs1_busy), 64'd0);

    // ALU priority starves loads until the FIFO fills
    li = 0;
    bus.alu_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.alu_rd    = 5'(10 + c);
      bus.alu_value = {$urandom, $urandom};
      bus.load_valid = (li < 5);
      bus.load_rd    = 5'(16 + li);
      bus.load_value = 64'ha000 + 64'(li);
      tick(acc);
      if (acc) li++;
    end
    check_eq("full_ready", 64'(bus.load_ready), 64'd0);
    check_eq("full_pushes", 64'(li), 64'd4);
    bus.alu_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.load_valid = (li < 5);
      bus.load_rd    = 5'(16 + li);
      bus.load_value = 64'ha000 + 64'(li);
      tick(acc);
      if (acc) li++;
    end
    bus.load_valid = 1'b0;
    check_eq("drained_ready", 64'(bus.load_ready), 64'd1);

    // hazards: double issue stalls; reissue in the pop cycle keeps the bit set
    bus.load_issue_valid = 1'b1; bus.load_issue_rd = 5'd3;
    tick(acc);
    #1 check_eq("stall_x3", 64'(bus.load_issue_stall), 64'd1);
    tick(acc);
    bus.load_issue_valid = 1'b0;
    bus.load_valid = 1'b1; bus.load_rd = 5'd3; bus.load_value = 64'h33;
    tick(acc);
    bus.load_valid = 1'b0;
    tick(acc);
    bus.load_valid = 1'b1; bus.load_rd = 5'd3; bus.load_value = 64'h34;
    tick(acc);
    bus.load_valid = 1'b0;
    bus.load_issue_valid = 1'b1; bus.load_issue_rd = 5'd3;
    tick(acc);
    bus.load_issue_valid = 1'b0; bus.rs1 = 5'd3;
    #1 check_eq("set_wins_x3", 64'(bus.rs1_busy), 64'd1);
    check_eq("set_wins_rd", 64'(bus.rd), 64'd3);

    // random traffic with a producer that holds until accepted
    for (int c = 0; c < 60; c++) begin
      bus.alu_valid = ($urandom_range(0, 2) == 0);
      bus.alu_rd    = 5'($urandom_range(0, 31));
      bus.alu_value = {$urandom, $urandom};
      if (!bus.load_valid && ($urandom_range(0, 1) == 1)) begin
        bus.load_valid = 1'b1;
        bus.load_rd    = 5'($urandom_range(0, 31));
        bus.load_value = {$urandom, $urandom};
      end
      bus.load_issue_valid = ($urandom_range(0, 1) == 1);
      bus.load_issue_rd    = 5'($urandom_range(0, 31));
      bus.rs1 = 5'($urandom_range(0, 31));
      bus.rs2 = 5'($urandom_range(0, 31));
      tick(acc);
      if (acc) bus.load_valid = 1'b0;
    end
    idle_inputs();

    // reset during operation with queued loads and pending bits
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_value = 64'h2020;
    bus.load_issue_valid = 1'b1; bus.load_issue_rd = 5'd12;
    for (int c = 0; c < 3; c++) begin
      bus.load_valid = 1'b1; bus.load_rd = 5'(21 + c); bus.load_value = 64'h77 + 64'(c);
      tick(acc);
      bus.load_issue_valid = 1'b0;
    end
    idle_inputs();
    bus.rs1 = 5'd12;
    reset = 1'b0;
    tick(acc);
    tick(acc);
    reset = 1'b1;
    check_eq("rst_rd", 64'(bus.rd), 64'd0);
    check_eq("rst_value", bus.rd_store_value, 64'd0);
    check_eq("rst_ready", 64'(bus.load_ready), 64'd1);
    check_eq("rst_busy_x12", 64'(bus.rs1_busy), 64'd0);
    repeat (3) tick(acc);
    check_eq("rst_fifo_empty_rd", 64'(bus.rd), 64'd0);

`ifdef RV_X_WRITEBACK_FORWARD_EN
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_value = 64'h55;
    tick(acc);
    bus.alu_valid = 1'b0; bus.rs2 = 5'd9;
    #1 check_eq("fwd_x9_valid", 64'(bus.rs2_fwd_valid), 64'd1);
    check_eq("fwd_x9_value", bus.rs2_fwd_value, 64'h55);
    tick(acc);
    bus.rs2 = 5'd0;
    #1 check_eq("fwd_x0_valid", 64'(bus.rs2_fwd_valid), 64'd0);
`endif

    repeat (2) tick(acc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
